// File: rtl/euler_step_ctrl.sv
// Euler-step sequencer: walks `length` elements through read -> add -> multiply -> write.
// Optional MWAIT watchdog is enabled by defining MUL_TIMEOUT_EN.
module euler_step_ctrl #(
  parameter int ADD_SIZE = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADD_SIZE-1:0] src_base,
  input  logic [ADD_SIZE-1:0] dst_base,
  input  logic [ADD_SIZE-1:0] length,
  input  logic                ovf,
  input  logic                mul_done,
  output logic                rd_en,
  output logic [ADD_SIZE-1:0] rd_addr,
  output logic                mul_start,
  output logic                wr_en,
  output logic [ADD_SIZE-1:0] wr_addr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ADD, S_MSTART, S_MWAIT, S_WRITE, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_state_nx;
  logic [ADD_SIZE-1:0] r_src, r_dst, r_len, r_idx;
  logic                r_err;
  logic                w_timeout;
  logic                w_accept;
  logic                w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_idx == r_len - ADD_SIZE'(1));

`ifdef MUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;

  // r_tcnt holds (MWAIT cycles so far - 1) during MWAIT; cleared on the way in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_tcnt <= '0;
    else if (r_state == S_MSTART) r_tcnt <= '0;
    else if (r_state == S_MWAIT)  r_tcnt <= r_tcnt + TW'(1);
  end

  assign w_timeout = (r_state == S_MWAIT) && (r_tcnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nx = (length == '0) ? S_DONE : S_FETCH;
      S_FETCH:  w_state_nx = S_ADD;
      S_ADD:    w_state_nx = ovf ? S_ERR : S_MSTART;
      S_MSTART: w_state_nx = S_MWAIT;
      S_MWAIT: begin
        if (mul_done)       w_state_nx = ovf ? S_ERR : S_WRITE;
        else if (w_timeout) w_state_nx = S_ERR;
      end
      S_WRITE:  w_state_nx = S_NEXT;
      S_NEXT:   w_state_nx = w_last ? S_DONE : S_FETCH;
      S_DONE:   w_state_nx = S_IDLE;
      S_ERR:    w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Run context is captured once at start so input changes mid-run are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src <= src_base;
        r_dst <= dst_base;
        r_len <= length;
        r_idx <= '0;
        r_err <= 1'b0;
      end else if (r_state == S_NEXT && !w_last) begin
        r_idx <= r_idx + ADD_SIZE'(1);
      end
      if (w_state_nx == S_ERR) r_err <= 1'b1;
    end
  end

  assign rd_en     = (r_state == S_FETCH);
  assign rd_addr   = r_src + r_idx;
  assign mul_start = (r_state == S_MSTART);
  assign wr_en     = (r_state == S_WRITE);
  assign wr_addr   = r_dst + r_idx;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) || (r_state == S_ERR);
  assign err       = r_err;

endmodule

// File: tb/tb_euler_step_ctrl.sv
// Self-checking bench for euler_step_ctrl: multiplier model + scenario tasks + random runs.
module tb_euler_step_ctrl;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0, dst_base = '0, length = '0;
  logic          ovf = 1'b0, mul_done = 1'b0;
  logic          rd_en, mul_start, wr_en, busy, done, err;
  logic [AW-1:0] rd_addr, wr_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  euler_step_ctrl #(.ADD_SIZE(AW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .length(length), .ovf(ovf), .mul_done(mul_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .mul_start(mul_start), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (rd_en) rd_log.push_back(rd_addr);
    if (wr_en) wr_log.push_back(wr_addr);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Multiplier model: mul_done L cycles after mul_start (L=0 means never), ovf on chosen start
  int lat_tab[int];
  int ovf_elem = -1;
  int ms_seen = 0, m_cnt = 0, m_elem = 0;

  always @(negedge clk) begin
    mul_done <= 1'b0;
    ovf      <= 1'b0;
    if (m_cnt > 0) begin
      if (m_cnt == 1) begin
        mul_done <= 1'b1;
        ovf      <= (m_elem == ovf_elem);
      end
      m_cnt <= m_cnt - 1;
    end
    if (mul_start) begin
      m_cnt   <= lat_tab.exists(ms_seen) ? lat_tab[ms_seen] : 1;
      m_elem  <= ms_seen;
      ms_seen <= ms_seen + 1;
    end
  end

  // Results of the latest run
  int            run_total, run_dones, run_busy, run_ms;
  bit            run_tmo, run_err_acc;
  logic [AW-1:0] run_rd[$];
  logic [AW-1:0] run_wr[$];
  int            none[$];

  task automatic step;
    @(posedge clk); #2;
  endtask

  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] n,
                     input int fail, input int lats[$], input bit disturb);
    int acc, d0, b0, r0, w0, m0;
    for (int i = 0; i < lats.size(); i++) lat_tab[ms_seen + i] = lats[i];
    ovf_elem = (fail >= 0) ? ms_seen + fail : -1;
    @(posedge clk); #1;
    src_base = s; dst_base = d; length = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_base = AW'($urandom); dst_base = AW'($urandom); length = AW'($urandom);
    acc = cyc; d0 = done_cnt; b0 = busy_cnt; r0 = rd_log.size(); w0 = wr_log.size(); m0 = ms_seen;
    run_err_acc = err;
    run_tmo = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (disturb && i == 6) begin
        start = 1'b1; src_base = 16'h0100; dst_base = 16'h0200; length = 16'd9;
      end
      if (disturb && i == 8) start = 1'b0;
      step();
      if (done_cnt > d0) begin
        run_tmo = 1'b0;
        break;
      end
    end
    start = 1'b0;
    step();
    run_total = done_cyc - acc + 1;
    run_dones = done_cnt - d0;
    run_busy  = busy_cnt - b0;
    run_ms    = ms_seen - m0;
    run_rd.delete();
    run_wr.delete();
    for (int i = r0; i < rd_log.size(); i++) run_rd.push_back(rd_log[i]);
    for (int i = w0; i < wr_log.size(); i++) run_wr.push_back(wr_log[i]);
    checks++;
    if (run_tmo) begin
      errors++;
      $display("FAIL run_timeout: no done within bound (src=%h len=%0d)", s, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({rd_en, mul_start, wr_en, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b exp 000000", {rd_en, mul_start, wr_en, busy, done, err});
    end
    checks++;
    if (rd_addr !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: rd=%h wr=%h exp 0000/0000", rd_addr, wr_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b exp 0", busy);
    end
  endtask

  task automatic test_basic;
    run(16'h0010, 16'h0040, 16'd3, -1, '{4, 4, 4}, 1'b0);
    checks++;
    if (run_rd.size() != 3 || run_wr.size() != 3) begin
      errors++;
      $display("FAIL basic_counts: rd=%0d wr=%0d exp 3/3", run_rd.size(), run_wr.size());
    end
    for (int i = 0; i < run_rd.size() && i < 3; i++) begin
      checks++;
      if (run_rd[i] !== AW'(16'h0010 + i) || run_wr[i] !== AW'(16'h0040 + i)) begin
        errors++;
        $display("FAIL basic_addr[%0d]: rd=%h wr=%h exp %h/%h", i, run_rd[i], run_wr[i],
                 AW'(16'h0010 + i), AW'(16'h0040 + i));
      end
    end
    checks++;
    if (run_total != 28 || run_busy != 28 || run_dones != 1) begin
      errors++;
      $display("FAIL basic_timing: total=%0d busy=%0d dones=%0d exp 28/28/1", run_total, run_busy, run_dones);
    end
    checks++;
    if (err !== 1'b0 || run_ms != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: err=%b ms=%0d busy=%b exp 0/3/0", err, run_ms, busy);
    end
  endtask

  task automatic test_zero_length;
    run(16'h1234, 16'h5678, 16'd0, -1, none, 1'b0);
    checks++;
    if (run_total != 1 || run_dones != 1) begin
      errors++;
      $display("FAIL zero_len_timing: total=%0d dones=%0d exp 1/1", run_total, run_dones);
    end
    checks++;
    if (run_rd.size() != 0 || run_wr.size() != 0 || run_ms != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_activity: rd=%0d wr=%0d ms=%0d err=%b exp 0/0/0/0",
               run_rd.size(), run_wr.size(), run_ms, err);
    end
  endtask

  task automatic test_ovf_abort;
    run(16'h0020, 16'h0080, 16'd3, 1, '{3, 3, 3}, 1'b0);
    checks++;
    if (run_wr.size() != 1 || (run_wr.size() == 1 && run_wr[0] !== 16'h0080)) begin
      errors++;
      $display("FAIL ovf_writes: count=%0d first=%h exp 1/0080", run_wr.size(),
               (run_wr.size() > 0) ? run_wr[0] : 16'hxxxx);
    end
    checks++;
    if (err !== 1'b1 || run_dones != 1 || busy !== 1'b0 || run_total != 15) begin
      errors++;
      $display("FAIL ovf_status: err=%b dones=%0d busy=%b total=%0d exp 1/1/0/15",
               err, run_dones, busy, run_total);
    end
    run(16'h0030, 16'h00A0, 16'd2, -1, '{2, 2}, 1'b0);
    checks++;
    if (run_err_acc !== 1'b0 || err !== 1'b0 || run_wr.size() != 2) begin
      errors++;
      $display("FAIL ovf_restart: err_at_start=%b err=%b wr=%0d exp 0/0/2", run_err_acc, err, run_wr.size());
    end
  endtask

  task automatic test_mid_run_ignore;
    run(16'h0030, 16'h0090, 16'd3, -1, '{2, 3, 2}, 1'b1);
    checks++;
    if (run_rd.size() != 3 || run_dones != 1 || run_total != 23) begin
      errors++;
      $display("FAIL midrun_counts: rd=%0d dones=%0d total=%0d exp 3/1/23", run_rd.size(), run_dones, run_total);
    end
    for (int i = 0; i < run_rd.size() && i < 3; i++) begin
      checks++;
      if (run_rd[i] !== AW'(16'h0030 + i)) begin
        errors++;
        $display("FAIL midrun_rd[%0d]: got %h exp %h", i, run_rd[i], AW'(16'h0030 + i));
      end
    end
  endtask

  task automatic test_wrap;
    run(16'hFFFF, 16'hFFFE, 16'd3, -1, '{1, 2, 1}, 1'b0);
    checks++;
    if (run_rd.size() != 3 || run_wr.size() != 3) begin
      errors++;
      $display("FAIL wrap_counts: rd=%0d wr=%0d exp 3/3", run_rd.size(), run_wr.size());
    end
    for (int i = 0; i < run_rd.size() && i < 3 && i < run_wr.size(); i++) begin
      checks++;
      if (run_rd[i] !== AW'(32'hFFFF + i) || run_wr[i] !== AW'(32'hFFFE + i)) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: rd=%h wr=%h exp %h/%h", i, run_rd[i], run_wr[i],
                 AW'(32'hFFFF + i), AW'(32'hFFFE + i));
      end
    end
  endtask

  task automatic test_reset_mwait;
    int m0, w0, d0;
    bit seen;
    m0 = ms_seen; w0 = wr_log.size(); d0 = done_cnt;
    lat_tab[ms_seen] = 10;
    ovf_elem = -1;
    @(posedge clk); #1;
    src_base = 16'h0050; dst_base = 16'h00A0; length = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ms_seen > m0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmw_no_mul_start: got none exp one within 20 cycles");
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_en, mul_start, wr_en, busy, done, err} !== 6'b0 || rd_addr !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL rstmw_async: strobes=%b rd=%h wr=%h exp all zero",
               {rd_en, mul_start, wr_en, busy, done, err}, rd_addr, wr_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) step();
    checks++;
    if (wr_log.size() != w0 || done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmw_late_done: wr=%0d done=%0d busy=%b exp %0d/%0d/0",
               wr_log.size(), done_cnt, busy, w0, d0);
    end
    run(16'h0060, 16'h00B0, 16'd1, -1, '{2}, 1'b0);
    checks++;
    if (run_total != 8 || run_rd.size() != 1 || run_wr.size() != 1 || run_dones != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rstmw_fresh: total=%0d rd=%0d wr=%0d dones=%0d err=%b exp 8/1/1/1/0",
               run_total, run_rd.size(), run_wr.size(), run_dones, err);
    end
    else begin
      checks++;
      if (run_rd[0] !== 16'h0060 || run_wr[0] !== 16'h00B0) begin
        errors++;
        $display("FAIL rstmw_fresh_addr: rd=%h wr=%h exp 0060/00B0", run_rd[0], run_wr[0]);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      logic [AW-1:0] s, d;
      int n, fail, nrd, nwr, tot;
      int lats[$];
      s = AW'($urandom);
      d = AW'($urandom);
      n = $urandom_range(1, 5);
      fail = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      lats.delete();
      for (int i = 0; i < n; i++) lats.push_back($urandom_range(1, 5));
      // Reference: each finished element costs 5+W, an aborted one 3+W, plus the DONE/ERR cycle
      nrd = (fail < 0) ? n : fail + 1;
      nwr = (fail < 0) ? n : fail;
      tot = 1;
      for (int i = 0; i < nrd; i++) tot += ((i == fail) ? 3 : 5) + lats[i];
      run(s, d, AW'(n), fail, lats, 1'b0);
      checks++;
      if (run_total != tot || run_busy != tot || run_dones != 1) begin
        errors++;
        $display("FAIL rand%0d_timing: total=%0d busy=%0d dones=%0d exp %0d/%0d/1",
                 it, run_total, run_busy, run_dones, tot, tot);
      end
      checks++;
      if (run_rd.size() != nrd || run_wr.size() != nwr || err !== (fail >= 0)) begin
        errors++;
        $display("FAIL rand%0d_counts: rd=%0d wr=%0d err=%b exp %0d/%0d/%0d",
                 it, run_rd.size(), run_wr.size(), err, nrd, nwr, (fail >= 0));
      end
      for (int i = 0; i < run_rd.size() && i < nrd; i++) begin
        checks++;
        if (run_rd[i] !== AW'(s + i)) begin
          errors++;
          $display("FAIL rand%0d_rd[%0d]: got %h exp %h", it, i, run_rd[i], AW'(s + i));
        end
      end
      for (int i = 0; i < run_wr.size() && i < nwr; i++) begin
        checks++;
        if (run_wr[i] !== AW'(d + i)) begin
          errors++;
          $display("FAIL rand%0d_wr[%0d]: got %h exp %h", it, i, run_wr[i], AW'(d + i));
        end
      end
    end
  endtask

`ifdef MUL_TIMEOUT_EN
  task automatic test_timeout;
    run(16'h0001, 16'h0002, 16'd1, -1, '{0}, 1'b0);
    checks++;
    if (run_total != 68 || err !== 1'b1 || run_wr.size() != 0 || run_dones != 1) begin
      errors++;
      $display("FAIL timeout: total=%0d err=%b wr=%0d dones=%0d exp 68/1/0/1",
               run_total, err, run_wr.size(), run_dones);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_ovf_abort();
    test_mid_run_ignore();
    test_wrap();
    test_reset_mwait();
    test_random();
`ifdef MUL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
